keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- Input-side companion to the 7-segment display driver: scans a 4x4 hex keypad matrix with one-hot active-low column drive, the same multiplexing scheme the display uses for digit selects.
- Debounces key presses and emits one event per press.
- Shifts each accepted hex digit into a 16-bit register, so `data` can feed the display driver's `data` input directly for on-board value entry.

Parameters:
- SCAN_BITS, 17: scan counter width; column dwell = 2^(SCAN_BITS-2) cycles, frame = 2^SCAN_BITS cycles; legal range >= 3.
- DEBOUNCE_SCANS, 4: number of consecutive identical frames after a change before the snapshot is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- col  output  4  column drive, active-low, exactly one bit low at any time
- row  input  4  row sense, active-low (externally pulled up)
- data  output  16  entered value; newest digit in [3:0]
- key_code  output  4  hex code of the last accepted key
- key_valid  output  1  one-cycle pulse per accepted key
- key_down  output  1  high while a key or keys are held (FSM in HELD)

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`.
- Scan counter:
  - SCAN_BITS-bit free-running counter, wraps.
  - colsel = counter[SCAN_BITS-1:SCAN_BITS-2]; col = ~(4'b0001 << colsel).
- Sampling:
  - On the edge where counter[SCAN_BITS-3:0] is all ones (last dwell cycle), ~row is stored into snapshot bits [colsel*4+3 : colsel*4].
  - Bit index = row*4 + col.
- Frame end: the edge where the counter is all ones.
  - The completed 16-bit snapshot, including the column-3 sample taken on that same edge, is compared with prev.
  - Equal: stab = min(stab+1, DEBOUNCE_SCANS). Different: stab = 0.
  - prev <= snapshot.
  - The snapshot is "accepted" on the frame where stab first becomes DEBOUNCE_SCANS, i.e. after DEBOUNCE_SCANS+1 identical frames.
- Key map, row0..row3 x col0..col3:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: 0 F E D
- FSM, evaluated only at frame end:
  - IDLE, accepted snapshot has exactly one bit set: key_code <= mapped code, data <= {data[11:0], code}, key_valid = 1 for the following cycle, go to HELD.
  - IDLE, accepted snapshot has two or more bits set: go to HELD with no event (rollover/ghost rejection).
  - IDLE, accepted snapshot is zero: stay in IDLE.
  - HELD, accepted snapshot is zero: go to IDLE.
  - HELD, accepted snapshot is non-zero (e.g. a second key added): stay in HELD, no event.
- key_down = (state == HELD). key_valid is never high for two consecutive cycles.
- Reset values:
  - counter 0, col 4'b1110
  - data 0, key_code 0, key_valid 0, key_down 0
  - snapshot 0, prev 0, stab 0, state IDLE
- Reset mid-press: all state is cleared; a key still held is re-debounced and emits exactly one new event.
- Latency: a key held from a frame boundary produces key_valid during cycle (DEBOUNCE_SCANS+1)*2^SCAN_BITS, counted from the first frame start.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN
- Defined:
  - In HELD with the same single key stably held, a 6-bit frame counter counts frames.
  - It emits a repeat event (key_valid pulse, data shift, same key_code) after 32 frames, then every 8 frames.
  - The counter clears on any snapshot change or on leaving HELD.
- Undefined: no repeat logic is present; exactly one event per press.

Test Plan:
- All tests use SCAN_BITS=4, DEBOUNCE_SCANS=2, so frame = 16 cycles. The bench models the keypad combinationally: row[r] = 0 when col[c] = 0 and key (r,c) is pressed.
- Reset, no keys: col steps 1110, 1101, 1011, 0111 every 4 cycles; data=0, key_valid never asserts over 200 cycles.
- Key (1,2) held from reset release: a single key_valid pulse at cycle 48 with key_code=6, data=16'h0006, key_down=1; release -> key_down=0 after 3 more frames.
- Press/release 1, 2, 3, A, then 5: data sequence 0001, 0012, 0123, 123A, 23A5; exactly one pulse per press.
- Bounce: key toggles every 20 cycles for 100 cycles, then holds -> no event during bounce, one event 3 frames after it settles.
- Two keys (0,0) and (3,3) held together -> key_down=1, no key_valid, data unchanged; releasing both returns to IDLE; reset asserted mid-hold clears data to 0.
- KEYPAD_AUTOREPEAT_EN: hold key 7 for 50 frames -> events at accept, +32 frames, +40, +48 frames; data=16'h7777.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines (col drive, row sense) plus the key-entry result bus.
// Latency: none; this is a plain bundle of wires.
// Backpressure: none; key_valid is a one-cycle pulse with no ready.
interface keypad_scan_if;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] data;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  // Scanner side: drives columns and results, senses rows.
  modport master (
    output col,
    output data,
    output key_code,
    output key_valid,
    output key_down,
    input  row
  );

  // Keypad/consumer side: drives rows, observes columns and results.
  modport slave (
    input  col,
    input  data,
    input  key_code,
    input  key_valid,
    input  key_down,
    output row
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low keypad scanner, frame debounce, hex key events, 16-bit entry register.
// Latency: key held from a frame start -> key_valid in cycle (DEBOUNCE_SCANS+1)*2^SCAN_BITS.
// Backpressure: none; one-cycle key_valid pulse. KEYPAD_AUTOREPEAT_EN enables held-key auto-repeat.
module keypad_scan #(
  parameter int SCAN_BITS      = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          reset,
  keypad_scan_if.master kp
);

  localparam int         DWELL_BITS = SCAN_BITS - 2;
  localparam logic [3:0] DB_MAX     = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0] DB_LAST    = 4'(DEBOUNCE_SCANS - 1);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           colsel;
  logic                 sample_edge;
  logic                 frame_end;
  logic [15:0]          snapshot;
  logic [15:0]          snap_now;
  logic [15:0]          prev;
  logic [3:0]           stab;
  logic                 same;
  logic                 accepted;
  logic                 single;
  logic [3:0]           hit_idx;
  logic [3:0]           code;
  state_t               state;

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [5:0]           rep_cnt;
  logic [15:0]          held_snap;
  logic                 rep_hold;
`endif

  // Row/column position of a key to its printed hex legend.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    key_map = 4'h0;
    case (idx)
      4'd0:  key_map = 4'h1;
      4'd1:  key_map = 4'h2;
      4'd2:  key_map = 4'h3;
      4'd3:  key_map = 4'hA;
      4'd4:  key_map = 4'h4;
      4'd5:  key_map = 4'h5;
      4'd6:  key_map = 4'h6;
      4'd7:  key_map = 4'hB;
      4'd8:  key_map = 4'h7;
      4'd9:  key_map = 4'h8;
      4'd10: key_map = 4'h9;
      4'd11: key_map = 4'hC;
      4'd12: key_map = 4'h0;
      4'd13: key_map = 4'hF;
      4'd14: key_map = 4'hE;
      4'd15: key_map = 4'hD;
    endcase
  endfunction

  // Top two counter bits pick the column; each column dwells 2^(SCAN_BITS-2) cycles.
  assign colsel      = scan_cnt[SCAN_BITS-1 -: 2];
  assign sample_edge = &scan_cnt[DWELL_BITS-1:0];
  assign frame_end   = &scan_cnt;
  assign kp.col      = ~(4'b0001 << colsel);

  // Snapshot as it stands after this edge's sample, so the frame-end compare
  // sees the column-3 rows captured on that same edge. Bit index is row*4+col.
  always_comb begin
    snap_now = snapshot;
    if (sample_edge) begin
      for (int r = 0; r < 4; r++) begin
        snap_now[{2'(r), colsel}] = ~kp.row[r];
      end
    end
  end

  // Locate the (highest) pressed key; only meaningful when exactly one is down.
  always_comb begin
    hit_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_now[i]) hit_idx = 4'(i);
    end
  end

  assign code     = key_map(hit_idx);
  assign same     = (snap_now == prev);
  assign single   = (snap_now != 16'd0) && ((snap_now & (snap_now - 16'd1)) == 16'd0);
  // Accept exactly once per stable run: on the frame where stab climbs to its cap.
  assign accepted = frame_end && same && (stab == DB_LAST);

`ifdef KEYPAD_AUTOREPEAT_EN
  // Repeat only counts frames where the accepted single key is still the only key, unchanged.
  assign rep_hold = same && single && (snap_now == held_snap);
`endif

  // Free-running scan counter, per-column sampling and frame-level stability count.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      snapshot <= '0;
      prev     <= '0;
      stab     <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (sample_edge) snapshot <= snap_now;
      if (frame_end) begin
        prev <= snap_now;
        if (!same) begin
          stab <= '0;
        end else if (stab != DB_MAX) begin
          stab <= stab + 4'd1;
        end
      end
    end
  end

  // Press/release FSM with registered event outputs; decisions only at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      kp.data      <= '0;
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt      <= '0;
      held_snap    <= '0;
`endif
    end else begin
      kp.key_valid <= 1'b0;
      if (frame_end) begin
        case (state)
          IDLE: begin
            if (accepted && single) begin
              kp.key_code  <= code;
              kp.data      <= {kp.data[11:0], code};
              kp.key_valid <= 1'b1;
              kp.key_down  <= 1'b1;
              state        <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt      <= '0;
              held_snap    <= snap_now;
`endif
            end else if (accepted && (snap_now != 16'd0)) begin
              // Two or more keys: ghosting/rollover, wait for full release silently.
              kp.key_down  <= 1'b1;
              state        <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt      <= '0;
              held_snap    <= '0;
`endif
            end
          end
          HELD: begin
            if (accepted && (snap_now == 16'd0)) begin
              kp.key_down <= 1'b0;
              state       <= IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_cnt     <= '0;
`endif
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat after 32 held frames; reloading 24 spaces later ones 8 frames apart.
            else if (rep_hold) begin
              if (rep_cnt == 6'd31) begin
                kp.key_code  <= code;
                kp.data      <= {kp.data[11:0], code};
                kp.key_valid <= 1'b1;
                rep_cnt      <= 6'd24;
              end else begin
                rep_cnt <= rep_cnt + 6'd1;
              end
            end else begin
              rep_cnt <= '0;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized keypad stimulus against a frame-level behavioural model.
// Keypad is modelled combinationally: row r pulled low when its pressed key's column is driven low.
// Runs with SCAN_BITS=4, DEBOUNCE_SCANS=2 (16-cycle frames); auto-repeat checked when enabled.
module tb_keypad_scan;

  localparam int SB    = 4;
  localparam int DB    = 2;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pressed = 16'd0;
  int          n_pass = 0;
  int          n_total = 0;

  keypad_scan_if kp_if ();

  keypad_scan #(.SCAN_BITS(SB), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp_if.master)
  );

  always #5 clk = ~clk;

  assign kp_if.row = {~|(pressed[15:12] & ~kp_if.col),
                      ~|(pressed[11:8]  & ~kp_if.col),
                      ~|(pressed[7:4]   & ~kp_if.col),
                      ~|(pressed[3:0]   & ~kp_if.col)};

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  // ---------------- behavioural reference model ----------------
  int          t;          // cycle index since reset release (cycle 0 = counter 0)
  logic [15:0] m_snap;     // keys seen in the most recent sample of each column
  logic [15:0] m_last;     // previous completed frame (virtual all-zero frame after reset)
  int          run_len;    // number of identical consecutive frames
  bit          held;
  int          hf;         // frames the accepted single key has stayed unchanged
  logic [15:0] held_key;
  logic        m_kv, m_down;
  logic [15:0] m_data;
  logic [3:0]  m_code;

  task automatic model_emit(input logic [15:0] keys);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) idx = i;
    m_kv   = 1'b1;
    m_code = keymap[idx];
    m_data = {m_data[11:0], keymap[idx]};
  endtask

  initial begin
    t = 0; m_snap = 0; m_last = 0; run_len = 1; held = 0; hf = 0; held_key = 0;
    m_kv = 0; m_down = 0; m_data = 0; m_code = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        t = 0; m_snap = 0; m_last = 0; run_len = 1; held = 0; hf = 0; held_key = 0;
        m_kv = 0; m_down = 0; m_data = 0; m_code = 0;
      end else begin
        m_kv = 1'b0;
        if (t % 4 == 3) begin
          for (int r = 0; r < 4; r++) m_snap[r*4 + (t/4)%4] = pressed[r*4 + (t/4)%4];
        end
        if (t % FRAME == FRAME - 1) begin
          if (m_snap == m_last) run_len++; else run_len = 1;
          if (held && m_snap == m_last && m_snap == held_key && $countones(m_snap) == 1) hf++;
          else hf = 0;
          if (run_len == DB + 1) begin
            if (!held && m_snap != 0) begin
              held = 1; hf = 0;
              held_key = ($countones(m_snap) == 1) ? m_snap : 16'd0;
              if ($countones(m_snap) == 1) model_emit(m_snap);
            end else if (held && m_snap == 0) begin
              held = 0;
            end
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (held && hf >= 32 && (hf - 32) % 8 == 0) model_emit(m_snap);
`endif
          m_down = held;
          m_last = m_snap;
        end
        t++;
      end
    end
  end

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic do_reset(input logic [15:0] keys);
    @(negedge clk);
    pressed = keys;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // Advance n cycles; tally DUT pulses and cycles where the DUT disagrees with the model.
  task automatic run(input int n, output int pulses, output int bad, output int first, output int last);
    logic [3:0] ecol;
    pulses = 0; bad = 0; first = -1; last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ecol = ~(4'b0001 << ((t / 4) % 4));
      if (kp_if.key_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = t;
        last = t;
      end
      if ({kp_if.col, kp_if.key_valid, kp_if.key_down, kp_if.key_code, kp_if.data} !==
          {ecol, m_kv, m_down, m_code, m_data}) bad++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int p, bad, f, l;
    do_reset(16'd0);
    n_total++; if (kp_if.col !== 4'b1110) $display("FAIL reset_col: got %b want 1110", kp_if.col); else n_pass++;
    n_total++; if (kp_if.data !== 16'h0) $display("FAIL reset_data: got %h want 0000", kp_if.data); else n_pass++;
    n_total++; if (kp_if.key_code !== 4'h0) $display("FAIL reset_code: got %h want 0", kp_if.key_code); else n_pass++;
    n_total++; if (kp_if.key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", kp_if.key_valid); else n_pass++;
    n_total++; if (kp_if.key_down !== 1'b0) $display("FAIL reset_down: got %b want 0", kp_if.key_down); else n_pass++;
    run(200, p, bad, f, l);
    n_total++; if (p !== 0) $display("FAIL idle_pulses: got %0d want 0", p); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL idle_trace: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (kp_if.data !== 16'h0) $display("FAIL idle_data: got %h want 0000", kp_if.data); else n_pass++;
  endtask

  task automatic test_single_key();
    int p, bad, f, l, rel_t, down_t;
    do_reset(16'd1 << 6);
    run(100, p, bad, f, l);
    n_total++; if (f !== 48) $display("FAIL single_latency: got cycle %0d want 48", f); else n_pass++;
    n_total++; if (p !== 1) $display("FAIL single_pulses: got %0d want 1", p); else n_pass++;
    n_total++; if (kp_if.key_code !== 4'h6) $display("FAIL single_code: got %h want 6", kp_if.key_code); else n_pass++;
    n_total++; if (kp_if.data !== 16'h0006) $display("FAIL single_data: got %h want 0006", kp_if.data); else n_pass++;
    n_total++; if (kp_if.key_down !== 1'b1) $display("FAIL single_down: got %b want 1", kp_if.key_down); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL single_trace: got %0d bad cycles want 0", bad); else n_pass++;
    for (int i = 0; i < FRAME && (t % FRAME) != 0; i++) @(negedge clk);
    pressed = 16'd0;
    rel_t   = t;
    down_t  = -1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (kp_if.key_down === 1'b0) begin
        down_t = t;
        break;
      end
    end
    n_total++; if (down_t - rel_t !== 3 * FRAME) $display("FAIL release_latency: got %0d cycles want %0d", down_t - rel_t, 3 * FRAME); else n_pass++;
  endtask

  task automatic test_sequence();
    int          keys [5] = '{0, 1, 2, 3, 5};
    logic [15:0] exp  [5] = '{16'h0001, 16'h0012, 16'h0123, 16'h123A, 16'h23A5};
    int p1, p2, b1, b2, f, l;
    do_reset(16'd0);
    for (int k = 0; k < 5; k++) begin
      pressed = 16'd1 << keys[k];
      run(80 + $urandom_range(0, 40), p1, b1, f, l);
      pressed = 16'd0;
      run(80 + $urandom_range(0, 40), p2, b2, f, l);
      n_total++; if (p1 + p2 !== 1) $display("FAIL seq_pulses[%0d]: got %0d want 1", k, p1 + p2); else n_pass++;
      n_total++; if (kp_if.data !== exp[k]) $display("FAIL seq_data[%0d]: got %h want %h", k, kp_if.data, exp[k]); else n_pass++;
      n_total++; if (b1 + b2 !== 0) $display("FAIL seq_trace[%0d]: got %0d bad cycles want 0", k, b1 + b2); else n_pass++;
    end
  endtask

  task automatic test_bounce();
    int p, pb, bad, bb, f, l, key;
    key = $urandom_range(0, 15);
    do_reset(16'd0);
    pb = 0; bb = 0;
    for (int i = 0; i < 5; i++) begin
      pressed = (i % 2 == 0) ? (16'd1 << key) : 16'd0;
      run(20, p, bad, f, l);
      pb += p; bb += bad;
    end
    n_total++; if (pb !== 0) $display("FAIL bounce_quiet: got %0d pulses want 0", pb); else n_pass++;
    run(100, p, bad, f, l);
    n_total++; if (f !== 128) $display("FAIL bounce_latency: got cycle %0d want 128", f); else n_pass++;
    n_total++; if (p !== 1) $display("FAIL bounce_pulses: got %0d want 1", p); else n_pass++;
    n_total++; if (kp_if.data !== {12'h0, keymap[key]}) $display("FAIL bounce_data: got %h want %h", kp_if.data, {12'h0, keymap[key]}); else n_pass++;
    n_total++; if (bb + bad !== 0) $display("FAIL bounce_trace: got %0d bad cycles want 0", bb + bad); else n_pass++;
  endtask

  task automatic test_ghost();
    int p, bad, f, l;
    do_reset(16'd0);
    pressed = 16'h0001;
    run(100, p, bad, f, l);
    pressed = 16'h0000;
    run(100, p, bad, f, l);
    n_total++; if (kp_if.data !== 16'h0001) $display("FAIL ghost_pre_data: got %h want 0001", kp_if.data); else n_pass++;
    pressed = 16'h8001;
    run(120, p, bad, f, l);
    n_total++; if (p !== 0) $display("FAIL ghost_pulses: got %0d want 0", p); else n_pass++;
    n_total++; if (kp_if.key_down !== 1'b1) $display("FAIL ghost_down: got %b want 1", kp_if.key_down); else n_pass++;
    n_total++; if (kp_if.data !== 16'h0001) $display("FAIL ghost_data: got %h want 0001", kp_if.data); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL ghost_trace: got %0d bad cycles want 0", bad); else n_pass++;
    pressed = 16'h0000;
    run(100, p, bad, f, l);
    n_total++; if (kp_if.key_down !== 1'b0 || p !== 0) $display("FAIL ghost_release: got down=%b pulses=%0d want down=0 pulses=0", kp_if.key_down, p); else n_pass++;
    pressed = 16'h8001;
    run(80, p, bad, f, l);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_total++; if (kp_if.data !== 16'h0 || kp_if.key_down !== 1'b0) $display("FAIL ghost_reset: got data=%h down=%b want data=0000 down=0", kp_if.data, kp_if.key_down); else n_pass++;
    run(100, p, bad, f, l);
    n_total++; if (p !== 0 || kp_if.key_down !== 1'b1) $display("FAIL ghost_rehold: got pulses=%0d down=%b want pulses=0 down=1", p, kp_if.key_down); else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    int p, bad, f, l, key;
    key = $urandom_range(0, 15);
    do_reset(16'd0);
    pressed = 16'd1 << key;
    run(80, p, bad, f, l);
    n_total++; if (p !== 1) $display("FAIL midreset_first: got %0d pulses want 1", p); else n_pass++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_total++; if (kp_if.data !== 16'h0 || kp_if.key_valid !== 1'b0) $display("FAIL midreset_clear: got data=%h valid=%b want 0000/0", kp_if.data, kp_if.key_valid); else n_pass++;
    run(100, p, bad, f, l);
    n_total++; if (p !== 1 || f !== 48) $display("FAIL midreset_event: got pulses=%0d at %0d want 1 at 48", p, f); else n_pass++;
    n_total++; if (kp_if.data !== {12'h0, keymap[key]}) $display("FAIL midreset_data: got %h want %h", kp_if.data, {12'h0, keymap[key]}); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL midreset_trace: got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  task automatic test_repeat();
    int p, bad, f, l;
    do_reset(16'd1 << 8);
    run(53 * FRAME, p, bad, f, l);
    n_total++; if (f !== 48) $display("FAIL hold_first: got cycle %0d want 48", f); else n_pass++;
    n_total++; if (bad !== 0) $display("FAIL hold_trace: got %0d bad cycles want 0", bad); else n_pass++;
`ifdef KEYPAD_AUTOREPEAT_EN
    n_total++; if (p !== 4) $display("FAIL repeat_pulses: got %0d want 4", p); else n_pass++;
    n_total++; if (l !== 48 + 48 * FRAME) $display("FAIL repeat_last: got cycle %0d want %0d", l, 48 + 48 * FRAME); else n_pass++;
    n_total++; if (kp_if.data !== 16'h7777) $display("FAIL repeat_data: got %h want 7777", kp_if.data); else n_pass++;
`else
    n_total++; if (p !== 1) $display("FAIL hold_pulses: got %0d want 1", p); else n_pass++;
    n_total++; if (l !== 48) $display("FAIL hold_last: got cycle %0d want 48", l); else n_pass++;
    n_total++; if (kp_if.data !== 16'h0007) $display("FAIL hold_data: got %h want 0007", kp_if.data); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_ghost();
    test_reset_mid_press();
    test_repeat();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end want finish");
    $fatal(1, "timeout");
  end

endmodule
